uart_tx: RTL and testbench

UART transmitter that serialises bytes onto the `tx` line, paced by the shared baud-rate enable `clk_en` used by the receive path. It sits between on-chip byte producers (valid/ready handshake) and the UART TX pin, and pairs with the UART receiver on the far end of the link. A one-byte holding register in front of the shift register allows back-to-back frames with no idle gap.

---
 rtl/uart_pkg.sv | 31 +++
 rtl/uart_tx.sv | 165 ++++++++++++++++
 tb/tb_uart_tx.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM encoding, line levels and legal frame bounds,
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } uart_state_e;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  localparam int DATA_BITS_MIN = 5;
  localparam int DATA_BITS_MAX = 8;
  localparam int STOP_BITS_MIN = 1;
  localparam int STOP_BITS_MAX = 2;

  // XOR of the low 'bits' data bits, inverted for odd parity.
  function automatic logic frame_parity(input logic [7:0] data, input int bits, input logic odd);
    logic p;
    p = odd;
    for (int i = 0; i < 8; i++) begin
      if (i < bits) p ^= data[i];
    end
    return p;
  endfunction

endpackage

// File: rtl/uart_tx.sv
// UART transmitter with a one-byte holding register, paced by clk_en.
// Optional parity bit when UART_TX_PARITY_EN is defined.
//   state  | meaning
//   IDLE   | line high, waiting for a full holding register
//   START  | start bit on the line
//   DATA   | data bits, LSB first, bit_cnt counts up
//   PARITY | parity bit (UART_TX_PARITY_EN only)
//   STOP   | stop bit(s), stop_cnt counts down to terminal 0
module uart_tx
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done
);

  if (DATA_BITS < DATA_BITS_MIN || DATA_BITS > DATA_BITS_MAX ||
      STOP_BITS < STOP_BITS_MIN || STOP_BITS > STOP_BITS_MAX ||
      PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_cfg
    $error("uart_tx: illegal DATA_BITS, STOP_BITS or PARITY_ODD");
  end

  localparam logic [2:0] LAST_BIT  = 3'(DATA_BITS - 1);
  localparam logic       STOP_LAST = 1'(STOP_BITS - 1);

  uart_state_e state_q, state_d;
  logic [7:0]  hold_q;
  logic        hold_full_q;
  logic [7:0]  shift_q, shift_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        stop_cnt_q, stop_cnt_d;
  logic        tx_q, tx_d;
  logic        busy_q;
  logic        done_q, done_d;
  logic        load;
`ifdef UART_TX_PARITY_EN
  logic        par_q;
`endif

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    tx_d       = tx_q;
    done_d     = 1'b0;
    load       = 1'b0;
    if (clk_en) begin
      unique case (state_q)
        ST_IDLE: begin
          if (hold_full_q) begin
            load    = 1'b1;
            shift_d = hold_q;
            tx_d    = LINE_START;
            state_d = ST_START;
          end
        end
        ST_START: begin
          tx_d      = shift_q[0];
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt_q != LAST_BIT) begin
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
            bit_cnt_d = bit_cnt_q + 3'd1;
          end else begin
`ifdef UART_TX_PARITY_EN
            tx_d       = par_q;
            state_d    = ST_PARITY;
`else
            tx_d       = LINE_IDLE;
            stop_cnt_d = STOP_LAST;
            state_d    = ST_STOP;
`endif
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          tx_d       = LINE_IDLE;
          stop_cnt_d = STOP_LAST;
          state_d    = ST_STOP;
        end
`endif
        ST_STOP: begin
          if (stop_cnt_q == 1'b0) begin
            done_d = 1'b1;
            // A waiting byte starts immediately, with no idle period.
            if (hold_full_q) begin
              load    = 1'b1;
              shift_d = hold_q;
              tx_d    = LINE_START;
              state_d = ST_START;
            end else begin
              tx_d    = LINE_IDLE;
              state_d = ST_IDLE;
            end
          end else begin
            stop_cnt_d = stop_cnt_q - 1'b1;
          end
        end
        default: begin
          tx_d    = LINE_IDLE;
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      tx_q        <= LINE_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      tx_q       <= tx_d;
      busy_q     <= (state_d != ST_IDLE);
      done_q     <= done_d;
      // Load and acceptance are exclusive: tx_ready is low while the register is full.
      if (load) begin
        hold_full_q <= 1'b0;
      end else if (tx_valid && !hold_full_q) begin
        hold_full_q <= 1'b1;
        hold_q      <= tx_data;
      end
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= frame_parity(hold_q, DATA_BITS, PARITY_ODD != 0);
    end
  end
`endif

  assign tx_ready = ~hold_full_q;
  assign tx       = tx_q;
  assign tx_busy  = busy_q;
  assign tx_done  = done_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed self-checking bench for uart_tx: 8N1 and 5-bit/2-stop instances
// share one stimulus bus; parity instances are added when the macro is set.
`timescale 1ns/1ps
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clk_en = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx8, rdy8, busy8, done8;
  logic       tx5, rdy5, busy5, done5;
  logic       txe, txo;

  always #5 clk = ~clk;

  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy8), .tx(tx8), .tx_busy(busy8), .tx_done(done8));

  uart_tx #(.DATA_BITS(5), .STOP_BITS(2), .PARITY_ODD(0)) u_dut5 (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdy5), .tx(tx5), .tx_busy(busy5), .tx_done(done5));

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
  logic rdye, busye, donee, rdyo, busyo, doneo;
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(0)) u_even (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdye), .tx(txe), .tx_busy(busye), .tx_done(donee));
  uart_tx #(.DATA_BITS(8), .STOP_BITS(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .clk_en(clk_en), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(rdyo), .tx(txo), .tx_busy(busyo), .tx_done(doneo));
`else
  localparam int P = 0;
  assign txe = 1'b1;
  assign txo = 1'b1;
`endif

  localparam int L8 = 10 + P;
  localparam int L5 = 8 + P;
  localparam int NS = 512;
  localparam int S_TX8 = 0, S_DONE8 = 1, S_BUSY8 = 2, S_TX5 = 3, S_DONE5 = 4, S_BUSY5 = 5,
                 S_TXE = 6, S_TXO = 7;

  int checks = 0;
  int errors = 0;
  int div = 1;
  int phase = 0;
  int n_s = 0;
  logic s_tx8[NS], s_done8[NS], s_busy8[NS], s_tx5[NS], s_done5[NS], s_busy5[NS];
  logic s_txe[NS], s_txo[NS];

  // One clock: sample outputs 1ns after the edge, then set clk_en for the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
    if (n_s < NS) begin
      s_tx8[n_s] = tx8;  s_done8[n_s] = done8; s_busy8[n_s] = busy8;
      s_tx5[n_s] = tx5;  s_done5[n_s] = done5; s_busy5[n_s] = busy5;
      s_txe[n_s] = txe;  s_txo[n_s] = txo;
      n_s++;
    end
    phase  = (phase + 1) % div;
    clk_en = (phase == 0);
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic do_reset(input int new_div);
    div = new_div;
    phase = 0;
    tx_valid = 1'b0;
    rst = 1'b1;
    run(2);
    rst = 1'b0;
    run(2);
    n_s = 0;
  endtask

  task automatic push(input logic [7:0] b, input int bound, output bit ok);
    bit acc;
    tx_data = b;
    tx_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < bound; t++) begin
      acc = (rdy8 === 1'b1);
      tick();
      if (acc) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic samp(int sig, int i);
    if (i < 0 || i >= n_s) return 1'b0;
    case (sig)
      S_TX8:   return s_tx8[i];
      S_DONE8: return s_done8[i];
      S_BUSY8: return s_busy8[i];
      S_TX5:   return s_tx5[i];
      S_DONE5: return s_done5[i];
      S_BUSY5: return s_busy5[i];
      S_TXE:   return s_txe[i];
      default: return s_txo[i];
    endcase
  endfunction

  function automatic int find_start(int sig);
    for (int i = 0; i < n_s; i++) if (samp(sig, i) === 1'b0) return i;
    return -1;
  endfunction

  // Line level at the first cycle of each bit period, period k in bit k.
  function automatic logic [63:0] grab(int sig, int s, int n);
    logic [63:0] r;
    r = '0;
    for (int k = 0; k < n && k < 64; k++) r[k] = samp(sig, s + k * div);
    return r;
  endfunction

  // Cycles inside the frame whose level differs from the expected bit for that period.
  function automatic int glitches(int sig, int s, int n, logic [63:0] e);
    int g;
    g = 0;
    for (int i = s; i < s + n * div; i++)
      if (i < 0 || i >= n_s || samp(sig, i) !== e[(i - s) / div]) g++;
    return g;
  endfunction

  function automatic int count_hi(int sig);
    int c;
    c = 0;
    for (int i = 0; i < n_s; i++) if (samp(sig, i) === 1'b1) c++;
    return c;
  endfunction

  function automatic logic [63:0] frame8(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return 64'({1'b1, ^d, d, 1'b0});
`else
    return 64'({1'b1, d, 1'b0});
`endif
  endfunction

  function automatic logic [63:0] frame5(logic [7:0] d);
`ifdef UART_TX_PARITY_EN
    return 64'({2'b11, ^d[4:0], d[4:0], 1'b0});
`else
    return 64'({2'b11, d[4:0], 1'b0});
`endif
  endfunction

  task automatic test_reset();
    rst = 1'b1; tx_valid = 1'b1; tx_data = 8'h55; clk_en = 1'b1; div = 1; phase = 0;
    tick();
    checks++; if (tx8 !== 1'b1)   begin errors++; $display("FAIL reset_tx: got %b expected 1", tx8); end
    checks++; if (rdy8 !== 1'b1)  begin errors++; $display("FAIL reset_ready: got %b expected 1", rdy8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done8); end
    tx_valid = 1'b0;
    rst = 1'b0;
    n_s = 0;
    run(20);
    checks++; if (find_start(S_TX8) != -1) begin errors++; $display("FAIL reset_no_frame: start at %0d expected none", find_start(S_TX8)); end
  endtask

  task automatic test_single();
    bit ok;
    int s;
    logic [63:0] e;
    do_reset(4);
    push(8'hA5, 4, ok);
    tx_valid = 1'b0;
    checks++; if (ok !== 1'b1)   begin errors++; $display("FAIL single_accept: got %b expected 1", ok); end
    checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL single_ready_drop: got %b expected 0", rdy8); end
    checks++; if (tx8 !== 1'b1)  begin errors++; $display("FAIL single_no_start_same_cycle: got %b expected 1", tx8); end
    run(60);
    s = find_start(S_TX8);
    checks++; if (s < 1 || s > 4) begin errors++; $display("FAIL single_start_latency: got %0d expected 1..4", s); end
    e = frame8(8'hA5);
    checks++; if (grab(S_TX8, s, L8) !== e) begin errors++; $display("FAIL single_frame: got %h expected %h", grab(S_TX8, s, L8), e); end
    checks++; if (glitches(S_TX8, s, L8, e) != 0) begin errors++; $display("FAIL single_bit_width: got %0d bad cycles expected 0", glitches(S_TX8, s, L8, e)); end
    checks++; if (count_hi(S_DONE8) != 1) begin errors++; $display("FAIL single_done_count: got %0d expected 1", count_hi(S_DONE8)); end
    checks++; if (samp(S_DONE8, s + L8 * div) !== 1'b1) begin errors++; $display("FAIL single_done_pos: got %b expected 1", samp(S_DONE8, s + L8 * div)); end
    checks++; if (samp(S_BUSY8, s + L8 * div - 1) !== 1'b1) begin errors++; $display("FAIL single_busy_in_frame: got %b expected 1", samp(S_BUSY8, s + L8 * div - 1)); end
    checks++; if (samp(S_BUSY8, s + L8 * div) !== 1'b0) begin errors++; $display("FAIL single_busy_fall: got %b expected 0", samp(S_BUSY8, s + L8 * div)); end
  endtask

  task automatic test_parity();
`ifdef UART_TX_PARITY_EN
    bit ok;
    int se, so;
    do_reset(4);
    push(8'h07, 4, ok);
    tx_valid = 1'b0;
    run(60);
    se = find_start(S_TXE);
    so = find_start(S_TXO);
    checks++; if (grab(S_TXE, se, 11) !== 64'h00000000000006_0E) begin errors++; $display("FAIL parity_even_frame: got %h expected %h", grab(S_TXE, se, 11), 64'h60E); end
    checks++; if (samp(S_TXE, se + 9 * div) !== 1'b1) begin errors++; $display("FAIL parity_even_bit: got %b expected 1", samp(S_TXE, se + 9 * div)); end
    checks++; if (grab(S_TXO, so, 11) !== 64'h00000000000004_0E) begin errors++; $display("FAIL parity_odd_frame: got %h expected %h", grab(S_TXO, so, 11), 64'h40E); end
    checks++; if (samp(S_TXO, so + 9 * div) !== 1'b0) begin errors++; $display("FAIL parity_odd_bit: got %b expected 0", samp(S_TXO, so + 9 * div)); end
`endif
  endtask

  task automatic test_reduced();
    bit ok;
    int s;
    logic [63:0] e;
    do_reset(4);
    push(8'h1F, 4, ok);
    tx_valid = 1'b0;
    run(50);
    s = find_start(S_TX5);
    e = frame5(8'h1F);
    checks++; if (grab(S_TX5, s, L5) !== e) begin errors++; $display("FAIL reduced_frame_1f: got %h expected %h", grab(S_TX5, s, L5), e); end
    checks++; if (glitches(S_TX5, s, L5, e) != 0) begin errors++; $display("FAIL reduced_bit_width: got %0d bad cycles expected 0", glitches(S_TX5, s, L5, e)); end
    checks++; if (samp(S_BUSY5, s + L5 * div - 1) !== 1'b1 || samp(S_BUSY5, s + L5 * div) !== 1'b0)
      begin errors++; $display("FAIL reduced_frame_len: busy %b%b expected 10", samp(S_BUSY5, s + L5 * div - 1), samp(S_BUSY5, s + L5 * div)); end
    checks++; if (samp(S_DONE5, s + L5 * div) !== 1'b1) begin errors++; $display("FAIL reduced_done_pos: got %b expected 1", samp(S_DONE5, s + L5 * div)); end
    do_reset(4);
    push(8'hE0, 4, ok);
    tx_valid = 1'b0;
    run(50);
    s = find_start(S_TX5);
    e = frame5(8'hE0);
    checks++; if (grab(S_TX5, s, L5) !== e) begin errors++; $display("FAIL reduced_upper_ignored: got %h expected %h", grab(S_TX5, s, L5), e); end
  endtask

  task automatic test_back_to_back();
    bit ok1, ok2;
    int s;
    logic [63:0] e;
    do_reset(4);
    push(8'h00, 4, ok1);
    push(8'hFF, 20, ok2);
    tx_valid = 1'b0;
    checks++; if ((ok1 & ok2) !== 1'b1) begin errors++; $display("FAIL b2b_accept: got %b%b expected 11", ok1, ok2); end
    run(100);
    s = find_start(S_TX8);
    e = (frame8(8'hFF) << L8) | frame8(8'h00);
    checks++; if (grab(S_TX8, s, 2 * L8) !== e) begin errors++; $display("FAIL b2b_frames: got %h expected %h", grab(S_TX8, s, 2 * L8), e); end
    checks++; if (glitches(S_TX8, s, 2 * L8, e) != 0) begin errors++; $display("FAIL b2b_bit_width: got %0d bad cycles expected 0", glitches(S_TX8, s, 2 * L8, e)); end
    checks++; if (samp(S_BUSY8, s + L8 * div) !== 1'b1) begin errors++; $display("FAIL b2b_busy_between: got %b expected 1", samp(S_BUSY8, s + L8 * div)); end
    checks++; if (count_hi(S_DONE8) != 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", count_hi(S_DONE8)); end
  endtask

  task automatic test_reset_mid();
    bit ok1, ok2;
    int s, target;
    do_reset(4);
    push(8'hA5, 4, ok1);
    push(8'h3C, 20, ok2);
    tx_valid = 1'b0;
    s = find_start(S_TX8);
    checks++; if (s < 0) begin errors++; $display("FAIL midrst_start_seen: got %0d expected >=0", s); end
    target = s + 4 * div + 1;
    for (int t = 0; t < 100 && n_s - 1 < target; t++) tick();
    checks++; if (tx8 !== 1'b0) begin errors++; $display("FAIL midrst_data_bit3: got %b expected 0", tx8); end
    rst = 1'b1;
    tick();
    checks++; if (tx8 !== 1'b1)   begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx8); end
    checks++; if (rdy8 !== 1'b1)  begin errors++; $display("FAIL midrst_ready: got %b expected 1", rdy8); end
    checks++; if (busy8 !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %b expected 0", busy8); end
    checks++; if (done8 !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b expected 0", done8); end
    rst = 1'b0;
    n_s = 0;
    run(80);
    checks++; if (count_hi(S_DONE8) != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", count_hi(S_DONE8)); end
    checks++; if (find_start(S_TX8) != -1) begin errors++; $display("FAIL midrst_pending_dropped: start at %0d expected none", find_start(S_TX8)); end
  endtask

  task automatic test_backpressure();
    bit ok1, ok2, ok3;
    int s;
    logic [63:0] e;
    do_reset(1);
    push(8'h3C, 4, ok1);
    push(8'h81, 10, ok2);
    checks++; if (rdy8 !== 1'b0) begin errors++; $display("FAIL bp_ready_drop: got %b expected 0", rdy8); end
    push(8'h5A, 40, ok3);
    tx_valid = 1'b0;
    checks++; if ((ok1 & ok2 & ok3) !== 1'b1) begin errors++; $display("FAIL bp_accept: got %b%b%b expected 111", ok1, ok2, ok3); end
    run(50);
    s = find_start(S_TX8);
    e = (frame8(8'h5A) << (2 * L8)) | (frame8(8'h81) << L8) | frame8(8'h3C);
    checks++; if (grab(S_TX8, s, 3 * L8) !== e) begin errors++; $display("FAIL bp_order: got %h expected %h", grab(S_TX8, s, 3 * L8), e); end
    checks++; if (count_hi(S_DONE8) != 3) begin errors++; $display("FAIL bp_done_count: got %0d expected 3", count_hi(S_DONE8)); end
    checks++; if (samp(S_BUSY8, s + 3 * L8) !== 1'b0) begin errors++; $display("FAIL bp_busy_fall: got %b expected 0", samp(S_BUSY8, s + 3 * L8)); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_parity();
    test_reduced();
    test_back_to_back();
    test_reset_mid();
    test_backpressure();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation still running at %0t", $time);
    $fatal(1, "timeout");
  end

endmodule
